// File: rtl/irrigation_valve_sequencer_if.sv
// Request/valve bundle between the irrigation decision logic and the valve sequencer.
// IRRIG_CYCLE_CNT_EN adds the cycle_count run counter to the bundle.
interface irrigation_valve_sequencer_if;
    logic        asp_req;
    logic        got_req;
    logic        fill_req;
    logic        error_in;
    logic        alarm_clr;
    logic        sprinkler_valve;
    logic        dripper_valve;
    logic        supply_valve;
    logic        alarm;
    logic        busy;
`ifdef IRRIG_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    modport master (
        output asp_req, got_req, fill_req, error_in, alarm_clr,
        input  sprinkler_valve, dripper_valve, supply_valve, alarm, busy
`ifdef IRRIG_CYCLE_CNT_EN
        , input cycle_count
`endif
    );

    modport slave (
        input  asp_req, got_req, fill_req, error_in, alarm_clr,
        output sprinkler_valve, dripper_valve, supply_valve, alarm, busy
`ifdef IRRIG_CYCLE_CNT_EN
        , output cycle_count
`endif
    );
endinterface

// File: rtl/irrigation_valve_sequencer.sv
// Valve sequencer: sprinkler/dripper mutex, min-on, cooldown, run watchdog, sticky alarm; IRRIG_CYCLE_CNT_EN adds cycle_count.
// Latency 1 cycle (all outputs registered from next state); no backpressure, requests are levels sampled every cycle.
module irrigation_valve_sequencer #(
    parameter int MIN_ON_CYCLES  = 16,
    parameter int MIN_OFF_CYCLES = 8,
    parameter int MAX_RUN_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    irrigation_valve_sequencer_if.slave io
);
    typedef enum logic [2:0] {IDLE, SPRINKLE, DRIP, COOLDOWN, FAULT} state_t;

    localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_RUN_LAST = CNT_W'(MAX_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             run_req;
    logic             run_done;

    logic sprinkler_q, dripper_q, supply_q, alarm_q, busy_q;

    // cnt counts open cycles in a run and elapsed cycles in cooldown
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        run_req   = (state == SPRINKLE) ? io.asp_req : io.got_req;
        run_done  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (io.error_in)     state_nxt = FAULT;
                else if (io.asp_req) state_nxt = SPRINKLE;
                else if (io.got_req) state_nxt = DRIP;
            end
            SPRINKLE, DRIP: begin
                if (io.error_in) begin
                    state_nxt = FAULT;
                end else if (!run_req && cnt >= MIN_ON_LAST) begin
                    state_nxt = COOLDOWN;
                    cnt_nxt   = '0;
                    run_done  = 1'b1;
                end else if (run_req && cnt >= MAX_RUN_LAST) begin
                    state_nxt = FAULT;
                end
            end
            COOLDOWN: begin
                if (io.error_in)             state_nxt = FAULT;
                else if (cnt >= MIN_OFF_LAST) state_nxt = IDLE;
            end
            FAULT: begin
                cnt_nxt = '0;
                if (io.alarm_clr && !io.error_in) state_nxt = COOLDOWN;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sprinkler_q <= 1'b0;
            dripper_q   <= 1'b0;
            supply_q    <= 1'b0;
            alarm_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sprinkler_q <= (state_nxt == SPRINKLE);
            dripper_q   <= (state_nxt == DRIP);
            supply_q    <= (state_nxt != FAULT) && io.fill_req && !io.error_in;
            alarm_q     <= (state_nxt == FAULT);
            busy_q      <= (state_nxt == SPRINKLE) || (state_nxt == DRIP) ||
                           (state_nxt == COOLDOWN);
        end
    end

    assign io.sprinkler_valve = sprinkler_q;
    assign io.dripper_valve   = dripper_q;
    assign io.supply_valve    = supply_q;
    assign io.alarm           = alarm_q;
    assign io.busy            = busy_q;

`ifdef IRRIG_CYCLE_CNT_EN
    logic [15:0] cycle_count_q;

    // only normal run completions count; watchdog and error exits do not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 cycle_count_q <= '0;
        else if (run_done && cycle_count_q != 16'hFFFF) cycle_count_q <= cycle_count_q + 16'd1;
    end

    assign io.cycle_count = cycle_count_q;
`endif
endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// Bench for irrigation_valve_sequencer: reset vectors, hand sequences, and randomized run against a behavioural model.
module tb_irrigation_valve_sequencer;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 3;
    localparam int MAX_RUN = 20;

    logic clk;
    logic rst_n;
    irrigation_valve_sequencer_if vif();

    irrigation_valve_sequencer #(
        .MIN_ON_CYCLES (MIN_ON),
        .MIN_OFF_CYCLES(MIN_OFF),
        .MAX_RUN_CYCLES(MAX_RUN),
        .CNT_W         (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model: open-cycle count per run, cooldown cycles remaining
    int m_valve;   // 0 none, 1 sprinkler, 2 dripper
    int m_run;
    int m_cool;
    int m_cnt;
    bit m_fault;
    bit m_sup;

    task automatic model_reset();
        m_valve = 0; m_run = 0; m_cool = 0; m_cnt = 0; m_fault = 0; m_sup = 0;
    endtask

    task automatic model_step(input bit a, input bit g, input bit f, input bit e, input bit c);
        bit rq;
        if (m_fault) begin
            if (c && !e) begin m_fault = 0; m_cool = MIN_OFF; end
        end else if (e) begin
            m_fault = 1; m_valve = 0; m_cool = 0;
        end else if (m_valve != 0) begin
            rq = (m_valve == 1) ? a : g;
            if (!rq && m_run >= MIN_ON) begin
                m_valve = 0; m_cool = MIN_OFF;
                if (m_cnt < 65535) m_cnt++;
            end else if (rq && m_run >= MAX_RUN) begin
                m_valve = 0; m_fault = 1;
            end else begin
                m_run++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (a) begin
            m_valve = 1; m_run = 1;
        end else if (g) begin
            m_valve = 2; m_run = 1;
        end
        m_sup = !m_fault && f && !e;
    endtask

    function automatic logic [4:0] model_outs();
        return {m_valve == 1, m_valve == 2, m_sup, m_fault, (m_valve != 0) || (m_cool > 0)};
    endfunction

    function automatic logic [4:0] dut_outs();
        return {vif.sprinkler_valve, vif.dripper_valve, vif.supply_valve, vif.alarm, vif.busy};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input bit a, input bit g, input bit f, input bit e, input bit c);
        vif.asp_req = a; vif.got_req = g; vif.fill_req = f; vif.error_in = e; vif.alarm_clr = c;
        @(posedge clk);
        model_step(a, g, f, e, c);
        #1;
    endtask

    typedef struct {
        bit       asp, got, fill, err, clr;
        logic [4:0] exp;   // {sprinkler, dripper, supply, alarm, busy}
    } vec_t;

    vec_t tbl[18];
    int   open_cnt;
    bit   ra, rg, rf, re, rc;

    initial begin
        // min-on pulse, cooldown, then error override of min-on in DRIP
        tbl[0]  = '{1, 0, 0, 0, 0, 5'b10001};
        tbl[1]  = '{0, 0, 0, 0, 0, 5'b10001};
        tbl[2]  = '{0, 0, 0, 0, 0, 5'b10001};
        tbl[3]  = '{0, 0, 0, 0, 0, 5'b10001};
        tbl[4]  = '{0, 0, 0, 0, 0, 5'b00001};
        tbl[5]  = '{0, 0, 0, 0, 0, 5'b00001};
        tbl[6]  = '{0, 0, 0, 0, 0, 5'b00001};
        tbl[7]  = '{0, 0, 0, 0, 0, 5'b00000};
        tbl[8]  = '{0, 1, 1, 0, 0, 5'b01101};
        tbl[9]  = '{0, 1, 1, 0, 0, 5'b01101};
        tbl[10] = '{0, 1, 1, 1, 0, 5'b00010};
        tbl[11] = '{0, 1, 1, 1, 1, 5'b00010};
        tbl[12] = '{0, 0, 1, 0, 0, 5'b00010};
        tbl[13] = '{0, 0, 1, 0, 1, 5'b00101};
        tbl[14] = '{0, 0, 0, 0, 0, 5'b00001};
        tbl[15] = '{0, 0, 0, 0, 0, 5'b00001};
        tbl[16] = '{0, 0, 0, 0, 0, 5'b00000};
        tbl[17] = '{0, 0, 0, 0, 1, 5'b00000};

        rst_n = 1'b0;
        vif.asp_req = 0; vif.got_req = 0; vif.fill_req = 0; vif.error_in = 0; vif.alarm_clr = 0;
        model_reset();
        #12;
        chk("reset_outs", 16'(dut_outs()), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].asp, tbl[i].got, tbl[i].fill, tbl[i].err, tbl[i].clr);
            chk($sformatf("vec%0d", i), 16'(dut_outs()), 16'(tbl[i].exp));
        end

        // both requests high: sprinkler wins, dripper waits out cooldown and opens from IDLE
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 0);
            chk("both_req_sprinkler", 16'(dut_outs()), 16'b10001);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk("switch_cooldown", 16'(dut_outs()), 16'b00001);
        end
        cyc(0, 1, 0, 0, 0);
        chk("switch_idle", 16'(dut_outs()), 16'b00000);
        cyc(0, 1, 0, 0, 0);
        chk("switch_drip_open", 16'(dut_outs()), 16'b01001);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        chk("drain_idle", 16'(dut_outs()), 16'b00000);

        // watchdog: request held 30 cycles, valve open exactly MAX_RUN cycles
        open_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (vif.dripper_valve) open_cnt++;
        end
        chk("watchdog_open_cycles", 16'(open_cnt), 16'(MAX_RUN));
        chk("watchdog_fault", 16'(dut_outs()), 16'b00010);
        cyc(0, 0, 0, 0, 1);
        chk("clr_to_cooldown", 16'(dut_outs()), 16'b00001);
        cyc(0, 0, 0, 0, 0);
        chk("clr_cool2", 16'(dut_outs()), 16'b00001);
        cyc(0, 0, 0, 0, 0);
        chk("clr_cool3", 16'(dut_outs()), 16'b00001);
        cyc(0, 0, 0, 0, 0);
        chk("clr_idle", 16'(dut_outs()), 16'b00000);

        // supply concurrent with sprinkler, then asynchronous reset mid-run
        cyc(1, 0, 1, 0, 0);
        chk("supply_with_sprinkler", 16'(dut_outs()), 16'b10101);
        cyc(1, 0, 1, 0, 0);
        chk("supply_with_sprinkler2", 16'(dut_outs()), 16'b10101);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outs", 16'(dut_outs()), 16'd0);
        model_reset();
        vif.asp_req = 0; vif.got_req = 0; vif.fill_req = 0;
        #5 rst_n = 1'b1;
        #1;

`ifdef IRRIG_CYCLE_CNT_EN
        chk("cycle_count_after_reset", vif.cycle_count, 16'd0);
        for (int r = 0; r < 3; r++) begin
            cyc(1, 0, 0, 0, 0);
            for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
        end
        chk("cycle_count_three_runs", vif.cycle_count, 16'd3);
        for (int i = 0; i < 21; i++) cyc(1, 0, 0, 0, 0);
        chk("watchdog_alarm", 16'(vif.alarm), 16'd1);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        chk("cycle_count_no_watchdog", vif.cycle_count, 16'd3);
        #1 rst_n = 1'b0;
        #1 chk("cycle_count_reset", vif.cycle_count, 16'd0);
        model_reset();
        #5 rst_n = 1'b1;
        #1;
`endif

        // randomized levels with sticky requests against the model
        ra = 0; rg = 0; rf = 0;
        for (int i = 0; i < 2000; i++) begin
            ra ^= ($urandom_range(0, 5) == 0);
            rg ^= ($urandom_range(0, 5) == 0);
            rf ^= ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 59) == 0);
            rc = ($urandom_range(0, 7) == 0);
            cyc(ra, rg, rf, re, rc);
            chk($sformatf("rand%0d", i), 16'(dut_outs()), 16'(model_outs()));
`ifdef IRRIG_CYCLE_CNT_EN
            chk($sformatf("rand_cnt%0d", i), vif.cycle_count, 16'(m_cnt));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
